// File: rtl/ring_noc_pkg.sv
// Shared ring NoC definitions: packet field offsets, route codes, scheduler state.
package ring_noc_pkg;

   localparam int unsigned VALID_BIT = 48;
   localparam int unsigned TS_MSB    = 47;
   localparam int unsigned TS_LSB    = 32;

   localparam logic [1:0] DIR_LOCAL = 2'b00;
   localparam logic [1:0] DIR_EAST  = 2'b01;
   localparam logic [1:0] DIR_WEST  = 2'b10;

   typedef enum logic {
      NORMAL = 1'b0,
      BOOST  = 1'b1
   } sched_state_t;

   // Packet age in cycles; modular so it stays correct across the 16-bit wrap.
   function automatic logic [15:0] slot_age(input logic [15:0] now, input logic [15:0] ts);
      return 16'(now - ts);
   endfunction

endpackage

// File: rtl/oldest_slot_picker.sv
// Picks one eligible slot from a requester buffer: oldest first when
// RING_SCHED_AGE_EN is defined, otherwise lowest eligible index.
module oldest_slot_picker
   import ring_noc_pkg::*;
#(
   parameter logic [1:0]  OUT_PORT    = DIR_EAST,
   parameter int unsigned PACKET_SIZE = 49,
   parameter int unsigned BUFFER_SIZE = 4,
   parameter int unsigned PTR_LEN     = $clog2(BUFFER_SIZE)
) (
   input  logic [BUFFER_SIZE*PACKET_SIZE-1:0] i_buf,
   input  logic [BUFFER_SIZE*2-1:0]           i_route,
   input  logic [BUFFER_SIZE-1:0]             i_mask,
   input  logic [15:0]                        i_clk_counter,
   output logic                               o_found,
   output logic [PTR_LEN-1:0]                 o_idx,
   output logic [PACKET_SIZE-1:0]             o_packet
);

`ifndef RING_SCHED_AGE_EN
   logic w_unused_clk_counter;
   assign w_unused_clk_counter = ^i_clk_counter;
`endif

   // Strict compare keeps ties on the lower index.
   always_comb begin : pick
      logic [PACKET_SIZE-1:0] v_pkt;
      logic                   v_elig;
`ifdef RING_SCHED_AGE_EN
      logic [15:0]            v_age;
      logic [15:0]            v_best;
`endif
      o_found  = 1'b0;
      o_idx    = '0;
      o_packet = '0;
      v_pkt    = '0;
      v_elig   = 1'b0;
`ifdef RING_SCHED_AGE_EN
      v_age    = '0;
      v_best   = '0;
`endif
      for (int i = 0; i < BUFFER_SIZE; i++) begin
         v_pkt  = i_buf[i*PACKET_SIZE +: PACKET_SIZE];
         v_elig = v_pkt[VALID_BIT] && (i_route[2*i +: 2] == OUT_PORT) && !i_mask[i];
`ifdef RING_SCHED_AGE_EN
         v_age = slot_age(i_clk_counter, v_pkt[TS_MSB:TS_LSB]);
         if (v_elig && (!o_found || (v_age > v_best))) begin
            o_found  = 1'b1;
            o_idx    = PTR_LEN'(i);
            o_packet = v_pkt;
            v_best   = v_age;
         end
`else
         if (v_elig && !o_found) begin
            o_found  = 1'b1;
            o_idx    = PTR_LEN'(i);
            o_packet = v_pkt;
         end
`endif
      end
   end

endmodule

// File: rtl/ring_port_scheduler.sv
// Output-port scheduler: transit (hi) vs local injection (lo) with starvation boost.
// Selection policy inside each buffer is set by RING_SCHED_AGE_EN.
module ring_port_scheduler
   import ring_noc_pkg::*;
#(
   parameter logic [1:0]  OUT_PORT     = DIR_EAST,
   parameter int unsigned PACKET_SIZE  = 49,
   parameter int unsigned BUFFER_SIZE  = 4,
   parameter int unsigned PTR_LEN      = $clog2(BUFFER_SIZE),
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [15:0]                        clk_counter,
   input  logic                               backpressure,
   input  logic [BUFFER_SIZE*PACKET_SIZE-1:0] hi_buf,
   input  logic [BUFFER_SIZE*2-1:0]           hi_route,
   input  logic [BUFFER_SIZE*PACKET_SIZE-1:0] lo_buf,
   input  logic [BUFFER_SIZE*2-1:0]           lo_route,
   output logic [PACKET_SIZE-1:0]             out_packet,
   output logic                               grant_valid,
   output logic [PTR_LEN-1:0]                 grant_pos,
   output logic                               grant_in_high,
   output logic                               boost_active
);

   localparam int unsigned LW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

   sched_state_t           r_state;
   logic [LW-1:0]          r_lo_wait;
   logic [PACKET_SIZE-1:0] r_out_packet;
   logic                   r_grant_valid;
   logic [PTR_LEN-1:0]     r_grant_pos;
   logic                   r_grant_in_high;
   logic                   r_boost_active;

   logic [BUFFER_SIZE-1:0] w_hi_mask, w_lo_mask;
   logic                   w_hi_found, w_lo_found;
   logic [PTR_LEN-1:0]     w_hi_idx, w_lo_idx;
   logic [PACKET_SIZE-1:0] w_hi_pkt, w_lo_pkt;
   logic                   w_grant, w_sel_hi, w_lo_grant;
   logic [LW-1:0]          w_lo_wait_nxt;

   // Last cycle's winner is still in its buffer until the router clears it.
   assign w_hi_mask = (r_grant_valid &&  r_grant_in_high) ? (BUFFER_SIZE'(1) << r_grant_pos) : '0;
   assign w_lo_mask = (r_grant_valid && !r_grant_in_high) ? (BUFFER_SIZE'(1) << r_grant_pos) : '0;

   oldest_slot_picker #(
      .OUT_PORT(OUT_PORT), .PACKET_SIZE(PACKET_SIZE),
      .BUFFER_SIZE(BUFFER_SIZE), .PTR_LEN(PTR_LEN)
   ) u_hi_pick (
      .i_buf(hi_buf), .i_route(hi_route), .i_mask(w_hi_mask), .i_clk_counter(clk_counter),
      .o_found(w_hi_found), .o_idx(w_hi_idx), .o_packet(w_hi_pkt)
   );

   oldest_slot_picker #(
      .OUT_PORT(OUT_PORT), .PACKET_SIZE(PACKET_SIZE),
      .BUFFER_SIZE(BUFFER_SIZE), .PTR_LEN(PTR_LEN)
   ) u_lo_pick (
      .i_buf(lo_buf), .i_route(lo_route), .i_mask(w_lo_mask), .i_clk_counter(clk_counter),
      .o_found(w_lo_found), .o_idx(w_lo_idx), .o_packet(w_lo_pkt)
   );

   assign w_grant    = w_hi_found || w_lo_found;
   assign w_sel_hi   = (r_state == NORMAL) ? w_hi_found : !w_lo_found;
   assign w_lo_grant = w_grant && !w_sel_hi;

   // Starvation counter, saturating at the boost threshold.
   always_comb begin
      w_lo_wait_nxt = r_lo_wait;
      if (!w_lo_found || w_lo_grant) begin
         w_lo_wait_nxt = '0;
      end else if (r_lo_wait != LW'(STARVE_LIMIT)) begin
         w_lo_wait_nxt = r_lo_wait + LW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state         <= NORMAL;
         r_lo_wait       <= '0;
         r_out_packet    <= '0;
         r_grant_valid   <= 1'b0;
         r_grant_pos     <= '0;
         r_grant_in_high <= 1'b0;
         r_boost_active  <= 1'b0;
      end else if (backpressure) begin
         r_out_packet  <= '0;
         r_grant_valid <= 1'b0;
      end else begin
         if (w_grant) begin
            r_out_packet    <= w_sel_hi ? w_hi_pkt : w_lo_pkt;
            r_grant_valid   <= 1'b1;
            r_grant_pos     <= w_sel_hi ? w_hi_idx : w_lo_idx;
            r_grant_in_high <= w_sel_hi;
         end else begin
            r_out_packet  <= '0;
            r_grant_valid <= 1'b0;
         end
         r_lo_wait <= w_lo_wait_nxt;
         case (r_state)
            NORMAL: begin
               if ((STARVE_LIMIT > 0) && (w_lo_wait_nxt == LW'(STARVE_LIMIT))) begin
                  r_state        <= BOOST;
                  r_boost_active <= 1'b1;
               end
            end
            BOOST: begin
               if (w_lo_grant || !w_lo_found) begin
                  r_state        <= NORMAL;
                  r_boost_active <= 1'b0;
               end
            end
            default: begin
               r_state        <= NORMAL;
               r_boost_active <= 1'b0;
            end
         endcase
      end
   end

   assign out_packet    = r_out_packet;
   assign grant_valid   = r_grant_valid;
   assign grant_pos     = r_grant_pos;
   assign grant_in_high = r_grant_in_high;
   assign boost_active  = r_boost_active;

endmodule

// File: tb/tb_ring_port_scheduler.sv
// Directed scoreboard bench for ring_port_scheduler (east port, STARVE_LIMIT=3).
module tb_ring_port_scheduler;
   import ring_noc_pkg::*;

   localparam int unsigned PS = 49;
   localparam int unsigned BS = 4;
   localparam int unsigned PL = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [15:0]      clk_counter;
   logic             backpressure;
   logic [BS*PS-1:0] hi_buf, lo_buf;
   logic [BS*2-1:0]  hi_route, lo_route;
   logic [PS-1:0]    out_packet;
   logic             grant_valid;
   logic [PL-1:0]    grant_pos;
   logic             grant_in_high;
   logic             boost_active;

   always #5 clk = ~clk;

   ring_port_scheduler #(
      .OUT_PORT(2'b01), .PACKET_SIZE(PS), .BUFFER_SIZE(BS), .PTR_LEN(PL), .STARVE_LIMIT(3)
   ) dut (
      .clk(clk), .rst_n(rst_n), .clk_counter(clk_counter), .backpressure(backpressure),
      .hi_buf(hi_buf), .hi_route(hi_route), .lo_buf(lo_buf), .lo_route(lo_route),
      .out_packet(out_packet), .grant_valid(grant_valid), .grant_pos(grant_pos),
      .grant_in_high(grant_in_high), .boost_active(boost_active)
   );

   typedef struct {
      string         tag;
      logic          v;
      logic [PS-1:0] pkt;
      logic [PL-1:0] pos;
      logic          hi;
      logic          boost;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [PS-1:0] mk(input logic [15:0] ts, input logic [15:0] src,
                                        input logic [15:0] dst);
      return {1'b1, ts, src, dst};
   endfunction

   task automatic set_hi(input int i, input logic [PS-1:0] p, input logic [1:0] r);
      hi_buf[i*PS +: PS] = p;
      hi_route[2*i +: 2] = r;
   endtask

   task automatic set_lo(input int i, input logic [PS-1:0] p, input logic [1:0] r);
      lo_buf[i*PS +: PS] = p;
      lo_route[2*i +: 2] = r;
   endtask

   task automatic push(input string tag, input logic v, input logic [PS-1:0] pkt,
                       input logic [PL-1:0] pos, input logic hi, input logic boost);
      exp_t e;
      e.tag = tag; e.v = v; e.pkt = pkt; e.pos = pos; e.hi = hi; e.boost = boost;
      exp_q.push_back(e);
   endtask

   // One clock edge, then compare the registered outputs against the oldest expectation.
   task automatic step();
      exp_t e;
      @(posedge clk);
      #1;
      checks++;
      assert (exp_q.size() > 0) else begin
         errors++;
         $error("FAIL scoreboard_empty observed 0 expected 1");
      end
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk({e.tag, "_valid"}, 64'(grant_valid), 64'(e.v));
         chk({e.tag, "_pkt"}, 64'(out_packet), 64'(e.pkt));
         chk({e.tag, "_boost"}, 64'(boost_active), 64'(e.boost));
         if (e.v) begin
            chk({e.tag, "_pos"}, 64'(grant_pos), 64'(e.pos));
            chk({e.tag, "_inhigh"}, 64'(grant_in_high), 64'(e.hi));
         end
      end
   endtask

   logic [PS-1:0] pa, pb, pc, pd, pe, pf, pg, ph, pw0, pw1, pl0, pl1, pfirst, psecond;
   int            first, second;

   initial begin
      rst_n = 1'b0; clk_counter = '0; backpressure = 1'b0;
      hi_buf = '0; lo_buf = '0; hi_route = '0; lo_route = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pkt", 64'(out_packet), 64'd0);
      chk("rst_valid", 64'(grant_valid), 64'd0);
      chk("rst_pos", 64'(grant_pos), 64'd0);
      chk("rst_inhigh", 64'(grant_in_high), 64'd0);
      chk("rst_boost", 64'(boost_active), 64'd0);
      rst_n = 1'b1;

      // Single request; a wrong-route slot alongside it must be ignored.
      clk_counter = 16'd10;
      pa = mk(16'd5, 16'h0A0A, 16'h0001);
      set_hi(2, pa, DIR_EAST);
      set_hi(1, mk(16'd1, 16'h0B0B, 16'h0002), DIR_WEST);
      push("single", 1'b1, pa, 2'd2, 1'b1, 1'b0); step();
      push("no_regrant", 1'b0, '0, 2'd0, 1'b0, 1'b0); step();
      set_hi(2, '0, DIR_LOCAL); set_hi(1, '0, DIR_LOCAL);
      push("idle1", 1'b0, '0, 2'd0, 1'b0, 1'b0); step();

      // Age order: ts 100 at slot 0, ts 40 at slot 3, now = 120.
      clk_counter = 16'd120;
      pb = mk(16'd100, 16'h0001, 16'h000B);
      pc = mk(16'd40,  16'h0002, 16'h000C);
      set_hi(0, pb, DIR_EAST); set_hi(3, pc, DIR_EAST);
`ifdef RING_SCHED_AGE_EN
      first = 3; second = 0; pfirst = pc; psecond = pb;
`else
      first = 0; second = 3; pfirst = pb; psecond = pc;
`endif
      push("age_first", 1'b1, pfirst, PL'(first), 1'b1, 1'b0); step();
      push("age_second", 1'b1, psecond, PL'(second), 1'b1, 1'b0); step();
      set_hi(first, '0, DIR_LOCAL);
      push("age_masked", 1'b0, '0, 2'd0, 1'b0, 1'b0); step();
      set_hi(second, '0, DIR_LOCAL);

      // Timestamp wrap on the transit buffer.
      clk_counter = 16'h0003;
      pw0 = mk(16'hFFF0, 16'h0003, 16'h0010);
      pw1 = mk(16'h0001, 16'h0004, 16'h0011);
      set_hi(0, pw0, DIR_EAST); set_hi(1, pw1, DIR_EAST);
      push("wrap_hi", 1'b1, pw0, 2'd0, 1'b1, 1'b0); step();
      set_hi(0, '0, DIR_LOCAL); set_hi(1, '0, DIR_LOCAL);
      push("wrap_idle", 1'b0, '0, 2'd0, 1'b0, 1'b0); step();

      // Wrap on the local buffer with the old packet at the higher index.
      pl0 = mk(16'h0001, 16'h0005, 16'h0012);
      pl1 = mk(16'hFFF0, 16'h0006, 16'h0013);
      set_lo(0, pl0, DIR_EAST); set_lo(1, pl1, DIR_EAST);
`ifdef RING_SCHED_AGE_EN
      push("wrap_lo", 1'b1, pl1, 2'd1, 1'b0, 1'b0); step();
`else
      push("wrap_lo", 1'b1, pl0, 2'd0, 1'b0, 1'b0); step();
`endif
      set_lo(0, '0, DIR_LOCAL); set_lo(1, '0, DIR_LOCAL);
      push("wrap_lo_idle", 1'b0, '0, 2'd0, 1'b0, 1'b0); step();

      // Backpressure holds grants, lo_wait and state.
      clk_counter = 16'd200;
      pd = mk(16'd190, 16'h0007, 16'h0020);
      pe = mk(16'd195, 16'h0008, 16'h0021);
      set_hi(1, pd, DIR_EAST); set_lo(2, pe, DIR_EAST);
      push("bp_pre", 1'b1, pd, 2'd1, 1'b1, 1'b0); step();
      chk("bp_pre_wait", 64'(dut.r_lo_wait), 64'd1);
      backpressure = 1'b1;
      for (int k = 0; k < 5; k++) begin
         push("bp_hold", 1'b0, '0, 2'd0, 1'b0, 1'b0); step();
         chk("bp_hold_wait", 64'(dut.r_lo_wait), 64'd1);
      end
      backpressure = 1'b0;
      push("bp_release", 1'b1, pd, 2'd1, 1'b1, 1'b0); step();
      chk("bp_release_wait", 64'(dut.r_lo_wait), 64'd2);
      push("bp_lo", 1'b1, pe, 2'd2, 1'b0, 1'b0); step();
      chk("bp_lo_wait", 64'(dut.r_lo_wait), 64'd0);
      set_hi(1, '0, DIR_LOCAL); set_lo(2, '0, DIR_LOCAL);
      push("bp_idle", 1'b0, '0, 2'd0, 1'b0, 1'b0); step();

      // Starvation: two always-full hi slots plus one lo request.
      clk_counter = 16'd500;
      pf = mk(16'd490, 16'h0009, 16'h0030);
      pg = mk(16'd490, 16'h000A, 16'h0031);
      ph = mk(16'd480, 16'h000B, 16'h0032);
      set_hi(0, pf, DIR_EAST); set_hi(1, pg, DIR_EAST); set_lo(0, ph, DIR_EAST);
      push("starve_h1", 1'b1, pf, 2'd0, 1'b1, 1'b0); step();
      push("starve_h2", 1'b1, pg, 2'd1, 1'b1, 1'b0); step();
      push("starve_h3", 1'b1, pf, 2'd0, 1'b1, 1'b1); step();
      chk("starve_state", 64'(dut.r_state), 64'(BOOST));
      push("starve_lo", 1'b1, ph, 2'd0, 1'b0, 1'b0); step();
      set_lo(0, '0, DIR_LOCAL);
      push("post_boost", 1'b1, pf, 2'd0, 1'b1, 1'b0); step();

      // Reset while a grant is on the outputs.
      rst_n = 1'b0;
      #1;
      chk("midrst_pkt", 64'(out_packet), 64'd0);
      chk("midrst_valid", 64'(grant_valid), 64'd0);
      chk("midrst_pos", 64'(grant_pos), 64'd0);
      chk("midrst_inhigh", 64'(grant_in_high), 64'd0);
      chk("midrst_boost", 64'(boost_active), 64'd0);
      chk("midrst_state", 64'(dut.r_state), 64'(NORMAL));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      push("after_rst", 1'b1, pf, 2'd0, 1'b1, 1'b0); step();

      checks++;
      assert (exp_q.size() == 0) else begin
         errors++;
         $error("FAIL scoreboard_leftover observed %0d expected 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
